// File: rtl/fpu_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_wb_pkg
// Description : Shared types and constants for the fpadd writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_wb_pkg;

    localparam logic [31:0] NANBOX_HI = 32'hFFFF_FFFF;
    localparam int          FLAGS_W   = 5;
    // Widest destination tag a writeback entry can carry.
    localparam int          TAG_MAX_W = 16;

    typedef struct packed {
        logic [63:0]          data;
        logic [FLAGS_W-1:0]   flags;
        logic                 denorm;
        logic [TAG_MAX_W-1:0] tag;
    } wb_entry_t;

    // Single-precision results live in [63:32] and are NaN-boxed into 64 bits.
    function automatic wb_entry_t format_entry(
        input logic [63:0]          result,
        input logic [FLAGS_W-1:0]   flags,
        input logic                 denorm,
        input logic                 sp,
        input logic [TAG_MAX_W-1:0] tag
    );
        wb_entry_t e;
        e.data   = sp ? {NANBOX_HI, result[63:32]} : result;
        e.flags  = flags;
        e.denorm = denorm;
        e.tag    = tag;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_sync_fifo
// Description : Synchronous FIFO of writeback entries with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_sync_fifo
    import fpu_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  wb_entry_t              i_wdata,
    output wb_entry_t              o_rdata,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [PTR_W:0]     r_count;
    logic               w_push;
    logic               w_pop;

    // Guards keep the FIFO consistent even if a caller ignores full/empty.
    assign w_push = i_push && (r_count != (PTR_W + 1)'(DEPTH));
    assign w_pop  = i_pop  && (r_count != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fpadd_wb.sv
`default_nettype none
// ============================================================================
// Module      : fpadd_wb
// Description : fpadd writeback stage: NaN-boxing, result FIFO, sticky fflags.
// Revision    : 1.0 - initial release
// ============================================================================
module fpadd_wb
    import fpu_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [63:0]            in_result,
    input  logic [FLAGS_W-1:0]     in_flags,
    input  logic                   in_denorm,
    input  logic                   in_p,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [63:0]            out_data,
    output logic [FLAGS_W-1:0]     out_flags,
    output logic                   out_denorm,
    output logic [TAG_W-1:0]       out_tag,
    output logic [FLAGS_W-1:0]     fflags,
    input  logic                   csr_we,
    input  logic [FLAGS_W-1:0]     csr_wdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]   w_count;
    logic               w_push;
    logic               w_pop;
    wb_entry_t          w_entry;
    wb_entry_t          w_head;
    logic [FLAGS_W-1:0] r_fflags;

    // Ready ignores out_ready: a full FIFO never accepts, even when popping.
    assign in_ready  = reset && (w_count < CNT_W'(DEPTH));
    assign out_valid = reset && (w_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign w_entry = format_entry(in_result, in_flags, in_denorm, in_p,
                                  TAG_MAX_W'(in_tag));

    wb_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_entry),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    assign count      = w_count;
    assign out_data   = out_valid ? w_head.data            : '0;
    assign out_flags  = out_valid ? w_head.flags           : '0;
    assign out_denorm = out_valid ? w_head.denorm          : 1'b0;
    assign out_tag    = out_valid ? w_head.tag[TAG_W-1:0]  : '0;

    generate
        if (TAG_W < TAG_MAX_W) begin : g_tag_hi
            logic w_unused_tag_hi;
            assign w_unused_tag_hi = ^w_head.tag[TAG_MAX_W-1:TAG_W];
        end
    endgenerate

    // Flags accumulate at accept time; a CSR write must not drop them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fflags <= '0;
        end else if (csr_we) begin
            r_fflags <= csr_wdata | (w_push ? in_flags : '0);
        end else if (w_push) begin
            r_fflags <= r_fflags | in_flags;
        end
    end

    assign fflags = r_fflags;

endmodule
`default_nettype wire

// File: tb/tb_fpadd_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpadd_wb
// Description : Directed and randomized self-checking bench for fpadd_wb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpadd_wb;

    localparam int DEPTH = 2;
    localparam int TAG_W = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_denorm, in_p;
    logic [63:0] in_result;
    logic [4:0]  in_flags;
    logic [4:0]  in_tag;
    logic        out_valid, out_ready, out_denorm;
    logic [63:0] out_data;
    logic [4:0]  out_flags, out_tag, fflags;
    logic        csr_we;
    logic [4:0]  csr_wdata;
    logic [1:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] d;
        logic [4:0]  f;
        logic        dn;
        logic [4:0]  t;
    } ent_t;

    ent_t        q[$];
    logic [4:0]  m_fflags;

    fpadd_wb #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_flags   (in_flags),
        .in_denorm  (in_denorm),
        .in_p       (in_p),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_flags  (out_flags),
        .out_denorm (out_denorm),
        .out_tag    (out_tag),
        .fflags     (fflags),
        .csr_we     (csr_we),
        .csr_wdata  (csr_wdata),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] r, input logic p,
                         input logic [4:0] f, input logic [4:0] t);
        in_valid  = v;
        in_result = r;
        in_p      = p;
        in_flags  = f;
        in_tag    = t;
        in_denorm = 1'b0;
    endtask

    initial begin
        reset = 1'b0; out_ready = 1'b0; csr_we = 1'b0; csr_wdata = '0;
        drive(1'b0, 64'h0, 1'b0, 5'h0, 5'h0);
        tick(); tick();

        // Reset state
        chk("rst_count",     64'(count),     64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_fflags",    64'(fflags),    64'd0);
        chk("rst_out_data",  out_data,       64'd0);
        reset = 1'b1; #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single precision NaN-boxing
        drive(1'b1, 64'h3F80_0000_0000_0000, 1'b1, 5'b00001, 5'd3);
        tick();
        drive(1'b0, 64'h0, 1'b0, 5'h0, 5'h0);
        chk("sp_out_valid", 64'(out_valid), 64'd1);
        chk("sp_out_data",  out_data,       64'hFFFF_FFFF_3F80_0000);
        chk("sp_out_tag",   64'(out_tag),   64'd3);
        chk("sp_out_flags", 64'(out_flags), 64'd1);
        chk("sp_fflags",    64'(fflags),    64'b00001);
        chk("sp_count",     64'(count),     64'd1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("empty_valid", 64'(out_valid), 64'd0);
        chk("empty_data",  out_data,       64'd0);
        chk("empty_tag",   64'(out_tag),   64'd0);

        // Double precision passthrough
        drive(1'b1, 64'h4000_0000_0000_0000, 1'b0, 5'b0, 5'd7);
        tick();
        drive(1'b0, 64'h0, 1'b0, 5'h0, 5'h0);
        chk("dp_out_data", out_data,     64'h4000_0000_0000_0000);
        chk("dp_out_tag",  64'(out_tag), 64'd7);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Back-pressure: third result must wait
        drive(1'b1, 64'h1111_0000_0000_0000, 1'b0, 5'b0, 5'd1); tick();
        drive(1'b1, 64'h2222_0000_0000_0000, 1'b0, 5'b0, 5'd2); tick();
        chk("bp_count",    64'(count),    64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 64'h3333_0000_0000_0000, 1'b0, 5'b0, 5'd3); tick();
        chk("bp_hold_count", 64'(count),   64'd2);
        chk("bp_head_tag",   64'(out_tag), 64'd1);
        chk("bp_head_data",  out_data,     64'h1111_0000_0000_0000);
        // Full with pop: pop only
        out_ready = 1'b1; tick();
        chk("fullpop_count", 64'(count),   64'd1);
        chk("fullpop_tag",   64'(out_tag), 64'd2);
        // Push and pop together at count 1
        tick();
        chk("pp_count", 64'(count),   64'd1);
        chk("pp_tag",   64'(out_tag), 64'd3);
        chk("pp_data",  out_data,     64'h3333_0000_0000_0000);
        drive(1'b0, 64'h0, 1'b0, 5'h0, 5'h0); tick();
        chk("drain_count", 64'(count), 64'd0);
        out_ready = 1'b0;

        // CSR / flags collision
        csr_we = 1'b1; csr_wdata = 5'b10000; tick();
        chk("csr_write", 64'(fflags), 64'b10000);
        csr_wdata = 5'b00000;
        drive(1'b1, 64'h5, 1'b0, 5'b00100, 5'd4); tick();
        csr_we = 1'b0;
        chk("csr_collide", 64'(fflags), 64'b00100);
        drive(1'b1, 64'h6, 1'b0, 5'b00001, 5'd5); tick();
        chk("flag_accum", 64'(fflags), 64'b00101);
        chk("pre_rst_count", 64'(count), 64'd2);

        // Reset mid-stream with a pending push
        reset = 1'b0; tick();
        chk("mid_rst_count",    64'(count),     64'd0);
        chk("mid_rst_valid",    64'(out_valid), 64'd0);
        chk("mid_rst_fflags",   64'(fflags),    64'd0);
        chk("mid_rst_in_ready", 64'(in_ready),  64'd0);
        reset = 1'b1;
        drive(1'b0, 64'h0, 1'b0, 5'h0, 5'h0);
        #1;
        chk("after_rst_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("after_rst_count", 64'(count), 64'd0);

        // Randomized traffic against a queue model
        m_fflags = '0;
        q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic        push, pop;
            ent_t        e;
            logic [63:0] r;
            r = {$urandom(), $urandom()};
            drive(1'($urandom_range(0, 3) != 0), r, 1'($urandom()),
                  5'($urandom()), 5'($urandom()));
            in_denorm = 1'($urandom());
            out_ready = 1'($urandom_range(0, 2) != 0);
            csr_we    = 1'($urandom_range(0, 15) == 0);
            csr_wdata = 5'($urandom());
            #1;
            chk("rnd_count",    64'(count),     64'(q.size()));
            chk("rnd_in_ready", 64'(in_ready),  64'(q.size() < DEPTH));
            chk("rnd_valid",    64'(out_valid), 64'(q.size() != 0));
            chk("rnd_fflags",   64'(fflags),    64'(m_fflags));
            if (q.size() != 0) begin
                chk("rnd_data",   out_data,        q[0].d);
                chk("rnd_flags",  64'(out_flags),  64'(q[0].f));
                chk("rnd_denorm", 64'(out_denorm), 64'(q[0].dn));
                chk("rnd_tag",    64'(out_tag),    64'(q[0].t));
            end else begin
                chk("rnd_empty_data", out_data, 64'd0);
            end
            push = in_valid && (q.size() < DEPTH);
            pop  = out_ready && (q.size() != 0);
            e.d  = in_p ? {32'hFFFF_FFFF, in_result[63:32]} : in_result;
            e.f  = in_flags;
            e.dn = in_denorm;
            e.t  = in_tag;
            if (csr_we)
                m_fflags = csr_wdata | (push ? in_flags : 5'b0);
            else if (push)
                m_fflags = m_fflags | in_flags;
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
